// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-side driver of the register file.
// Two producers (EXU, LSU) hand writeback results over valid/ready channels
// into private FIFOs. A round-robin arbiter pops one head per cycle into a
// registered RF write port (wen/waddr/wdata). Writes to x0 are consumed
// silently.
// Optional feature macro: RF_WB_PENDING_EN adds a per-register "pending"
// bitmap covering both FIFOs and the output register, used for RAW stalls.

module rf_wb_fifo #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [AW+DW-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW+DW-1:0] o_head
`ifdef RF_WB_PENDING_EN
  ,
  output logic [DEPTH*AW-1:0] o_slot_addr,
  output logic [DEPTH-1:0]    o_slot_vld
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = AW + DW;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  // Registered head: an entry pushed this edge is poppable only next edge.
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy update; reset discards all buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

`ifdef RF_WB_PENDING_EN
  logic [PTR_W-1:0] w_off;

  // Per-slot validity: slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    o_slot_addr = {(DEPTH*AW){1'b0}};
    o_slot_vld  = {DEPTH{1'b0}};
    w_off       = {PTR_W{1'b0}};
    for (int s = 0; s < DEPTH; s++) begin
      w_off                  = PTR_W'(s) - r_rd_ptr;
      o_slot_vld[s]          = ({1'b0, w_off} < r_count);
      o_slot_addr[s*AW +: AW] = r_mem[s][EW-1 -: AW];
    end
  end
`endif

endmodule

module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_waddr,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
`ifdef RF_WB_PENDING_EN
  output logic [2**ADDR_WIDTH-1:0] pending,
`endif
  output logic                  idle
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  // Round-robin pointer encoding: names the source favoured on a tie.
  localparam logic [0:0] RR_EXU = 1'b0;
  localparam logic [0:0] RR_LSU = 1'b1;

  logic                  w_exu_full, w_exu_empty, w_lsu_full, w_lsu_empty;
  logic [EW-1:0]         w_exu_head, w_lsu_head, w_sel_head;
  logic                  w_exu_ready, w_lsu_ready;
  logic                  w_exu_push, w_lsu_push;
  logic                  w_grant_exu, w_grant_lsu;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  logic [0:0]            r_rr;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  // Ready depends only on occupancy and reset, never on valid.
  assign w_exu_ready = !rst && !w_exu_full;
  assign w_lsu_ready = !rst && !w_lsu_full;
  assign exu_ready   = w_exu_ready;
  assign lsu_ready   = w_lsu_ready;
  assign w_exu_push  = exu_valid && w_exu_ready;
  assign w_lsu_push  = lsu_valid && w_lsu_ready;

`ifdef RF_WB_PENDING_EN
  logic [FIFO_DEPTH*ADDR_WIDTH-1:0] w_exu_slot_addr, w_lsu_slot_addr;
  logic [FIFO_DEPTH-1:0]            w_exu_slot_vld, w_lsu_slot_vld;
  logic [2**ADDR_WIDTH-1:0]         w_pending;
`endif

  rf_wb_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_exu_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_exu_push),
    .i_data      ({exu_waddr, exu_wdata}),
    .i_pop       (w_grant_exu),
    .o_full      (w_exu_full),
    .o_empty     (w_exu_empty),
    .o_head      (w_exu_head)
`ifdef RF_WB_PENDING_EN
    ,
    .o_slot_addr (w_exu_slot_addr),
    .o_slot_vld  (w_exu_slot_vld)
`endif
  );

  rf_wb_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_lsu_push),
    .i_data      ({lsu_waddr, lsu_wdata}),
    .i_pop       (w_grant_lsu),
    .o_full      (w_lsu_full),
    .o_empty     (w_lsu_empty),
    .o_head      (w_lsu_head)
`ifdef RF_WB_PENDING_EN
    ,
    .o_slot_addr (w_lsu_slot_addr),
    .o_slot_vld  (w_lsu_slot_vld)
`endif
  );

  // Grant selection: contested cycles follow rr, otherwise the lone non-empty source wins.
  always_comb begin
    w_grant_exu = 1'b0;
    w_grant_lsu = 1'b0;
    if (rst) begin
      w_grant_exu = 1'b0;
      w_grant_lsu = 1'b0;
    end else if (!w_exu_empty && !w_lsu_empty) begin
      if (r_rr == RR_EXU) begin
        w_grant_exu = 1'b1;
      end else begin
        w_grant_lsu = 1'b1;
      end
    end else if (!w_exu_empty) begin
      w_grant_exu = 1'b1;
    end else if (!w_lsu_empty) begin
      w_grant_lsu = 1'b1;
    end else begin
      w_grant_exu = 1'b0;
      w_grant_lsu = 1'b0;
    end
  end

  assign w_sel_head = w_grant_exu ? w_exu_head : w_lsu_head;
  assign w_sel_addr = w_sel_head[EW-1 -: ADDR_WIDTH];
  assign w_sel_data = w_sel_head[DATA_WIDTH-1:0];

  // RF write port register and rr update; x0 entries are popped without raising wen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= {ADDR_WIDTH{1'b0}};
      r_wdata <= {DATA_WIDTH{1'b0}};
      r_rr    <= RR_EXU;
    end else if (w_grant_exu || w_grant_lsu) begin
      r_wen   <= (w_sel_addr != {ADDR_WIDTH{1'b0}});
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
      r_rr    <= w_grant_exu ? RR_LSU : RR_EXU;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign wen   = r_wen;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign idle  = w_exu_empty && w_lsu_empty && !r_wen;

`ifdef RF_WB_PENDING_EN
  // Pending bitmap: every live FIFO entry plus an in-flight write marks its target; x0 never pends.
  always_comb begin
    w_pending = {(2**ADDR_WIDTH){1'b0}};
    for (int s = 0; s < FIFO_DEPTH; s++) begin
      if (w_exu_slot_vld[s]) begin
        w_pending[w_exu_slot_addr[s*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end else begin
        w_pending = w_pending;
      end
      if (w_lsu_slot_vld[s]) begin
        w_pending[w_lsu_slot_addr[s*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end else begin
        w_pending = w_pending;
      end
    end
    if (r_wen) begin
      w_pending[r_waddr] = 1'b1;
    end else begin
      w_pending = w_pending;
    end
    w_pending[0] = 1'b0;
  end

  assign pending = w_pending;
`endif

endmodule
